// File: rtl/brg_vvadd_xcel_fetch_ctrl.sv
// Vector-vector add fetch controller: issues A/B loads, reorders
// responses in an 8-slot buffer, emits sums in order, then signals.
module brg_vvadd_xcel_fetch_ctrl #(
  parameter int data_width_p = 32,
  parameter int addr_width_p = 32,
  parameter int max_out_credits_p = 8,
  parameter int len_width_p = 16,
  localparam int credit_counter_width_lp = $clog2(max_out_credits_p+1)
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,
  input  logic                               start_i,
  input  logic [addr_width_p-1:0]            a_addr_i,
  input  logic [addr_width_p-1:0]            b_addr_i,
  input  logic [len_width_p-1:0]             len_i,
  input  logic [addr_width_p-1:0]            signal_addr_i,
  output logic                               busy_o,
  output logic                               done_o,
  output logic                               tx_v_o,
  output logic                               tx_fetching_o,
  output logic [addr_width_p-1:0]            tx_addr_o,
  output logic [addr_width_p-1:0]            tx_signal_addr_o,
  output logic [4:0]                         tx_reg_id_o,
  input  logic                               tx_ready_i,
  input  logic [credit_counter_width_lp-1:0] tx_credits_i,
  input  logic                               tx_returned_v_i,
  input  logic [data_width_p-1:0]            tx_returned_data_i,
  input  logic [4:0]                         tx_returned_reg_id_i,
  output logic                               res_v_o,
  output logic [data_width_p-1:0]            res_data_o,
  output logic [len_width_p-1:0]             res_idx_o,
  input  logic                               res_ready_i
);

  typedef enum logic [2:0] {
    IDLE, FETCH, DRAIN, SIGNAL, WAIT_SIG, DONE
  } state_e;

  localparam logic [len_width_p-1:0] one_lp = len_width_p'(1);
  localparam logic [4:0] sig_tag_lp = 5'b01111;

  state_e state_r;

  logic [addr_width_p-1:0] a_base_r;
  logic [addr_width_p-1:0] b_base_r;
  logic [addr_width_p-1:0] sig_addr_r;
  logic [len_width_p-1:0]  len_r;
  logic [len_width_p-1:0]  iss_idx_r;
  logic [len_width_p-1:0]  head_r;
  logic                    iss_b_r;

  logic [7:0]              alloc_r;
  logic [7:0]              av_r;
  logic [7:0]              bv_r;
  logic [data_width_p-1:0] ad_r [8];
  logic [data_width_p-1:0] bd_r [8];

  logic [2:0] iss_slot;
  logic [2:0] head_slot;
  logic [2:0] rsp_slot;
  logic       rsp_op;
  logic       rsp_ld;
  logic       rsp_ok;
  logic       tx_fire;
  logic       pop;
  logic       credit_ok;
  logic       last_iss;

  assign iss_slot  = iss_idx_r[2:0];
  assign head_slot = head_r[2:0];
  assign rsp_slot  = tx_returned_reg_id_i[2:0];
  assign rsp_op    = tx_returned_reg_id_i[4];
  assign rsp_ld    = tx_returned_v_i
                   & ~tx_returned_reg_id_i[3];
  assign rsp_ok    = alloc_r[rsp_slot]
                   & ~(rsp_op ? bv_r[rsp_slot]
                              : av_r[rsp_slot]);
  assign tx_fire   = tx_v_o & tx_ready_i;
  assign credit_ok = tx_credits_i != '0;
  assign last_iss  = iss_idx_r == (len_r - one_lp);

  assign busy_o     = state_r != IDLE;
  assign done_o     = state_r == DONE;
  assign res_v_o    = alloc_r[head_slot]
                    & av_r[head_slot]
                    & bv_r[head_slot];
  assign res_data_o = ad_r[head_slot] + bd_r[head_slot];
  assign res_idx_o  = head_r;
  assign pop        = res_v_o & res_ready_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r          <= IDLE;
      a_base_r         <= '0;
      b_base_r         <= '0;
      sig_addr_r       <= '0;
      len_r            <= '0;
      iss_idx_r        <= '0;
      head_r           <= '0;
      iss_b_r          <= 1'b0;
      alloc_r          <= '0;
      av_r             <= '0;
      bv_r             <= '0;
      tx_v_o           <= 1'b0;
      tx_fetching_o    <= 1'b1;
      tx_addr_o        <= '0;
      tx_signal_addr_o <= '0;
      tx_reg_id_o      <= '0;
      for (int i = 0; i < 8; i++) begin
        ad_r[i] <= '0;
        bd_r[i] <= '0;
      end
    end else begin
      if (rsp_ld && rsp_ok) begin
        if (rsp_op) begin
          bv_r[rsp_slot] <= 1'b1;
          bd_r[rsp_slot] <= tx_returned_data_i;
        end else begin
          av_r[rsp_slot] <= 1'b1;
          ad_r[rsp_slot] <= tx_returned_data_i;
        end
      end
      // Pop and response never share a slot, so both may land.
      if (pop) begin
        alloc_r[head_slot] <= 1'b0;
        av_r[head_slot]    <= 1'b0;
        bv_r[head_slot]    <= 1'b0;
        head_r             <= head_r + one_lp;
      end
      if (tx_fire) begin
        tx_v_o        <= 1'b0;
        tx_fetching_o <= 1'b1;
      end
      unique case (state_r)
        IDLE: if (start_i) begin
          a_base_r   <= a_addr_i;
          b_base_r   <= b_addr_i;
          sig_addr_r <= signal_addr_i;
          len_r      <= len_i;
          iss_idx_r  <= '0;
          iss_b_r    <= 1'b0;
          head_r     <= '0;
          state_r    <= (len_i == '0) ? SIGNAL : FETCH;
        end
        FETCH: begin
          if (tx_fire) begin
            if (!iss_b_r) begin
              alloc_r[iss_slot] <= 1'b1;
              iss_b_r           <= 1'b1;
            end else begin
              iss_b_r   <= 1'b0;
              iss_idx_r <= iss_idx_r + one_lp;
              if (last_iss) state_r <= DRAIN;
            end
          end else if (!tx_v_o && credit_ok
                       && (iss_b_r || !alloc_r[iss_slot])) begin
            tx_v_o        <= 1'b1;
            tx_fetching_o <= 1'b1;
            tx_addr_o     <= (iss_b_r ? b_base_r : a_base_r)
                           + addr_width_p'(iss_idx_r);
            tx_reg_id_o   <= {iss_b_r, 1'b0, iss_slot};
          end
        end
        DRAIN: if (head_r == len_r) state_r <= SIGNAL;
        SIGNAL: begin
          if (tx_fire) begin
            state_r <= WAIT_SIG;
          end else if (!tx_v_o && credit_ok) begin
            tx_v_o           <= 1'b1;
            tx_fetching_o    <= 1'b0;
            tx_signal_addr_o <= sig_addr_r;
            tx_reg_id_o      <= sig_tag_lp;
          end
        end
        WAIT_SIG:
          if (tx_returned_v_i
              && tx_returned_reg_id_i == sig_tag_lp)
            state_r <= DONE;
        DONE: state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (reset_n_i && rsp_ld && !rsp_ok)
      $warning("vvadd fetch: dropped response tag %b",
               tx_returned_reg_id_i);
  end
`endif

endmodule

// File: tb/tb_brg_vvadd_xcel_fetch_ctrl.sv
// Directed bench for brg_vvadd_xcel_fetch_ctrl with a memory/network
// model and a per-cycle monitor of loads, signal store and results.
module tb_brg_vvadd_xcel_fetch_ctrl;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int CR = 8;
  localparam int LW = 16;
  localparam int CW = $clog2(CR+1);

  logic          clk = 1'b0;
  logic          reset_n_i = 1'b1;
  logic          start_i = 1'b0;
  logic [AW-1:0] a_addr_i = '0;
  logic [AW-1:0] b_addr_i = '0;
  logic [LW-1:0] len_i = '0;
  logic [AW-1:0] signal_addr_i = '0;
  logic          busy_o;
  logic          done_o;
  logic          tx_v_o;
  logic          tx_fetching_o;
  logic [AW-1:0] tx_addr_o;
  logic [AW-1:0] tx_signal_addr_o;
  logic [4:0]    tx_reg_id_o;
  logic          tx_ready_i = 1'b1;
  logic [CW-1:0] tx_credits_i = CW'(CR);
  logic          tx_returned_v_i = 1'b0;
  logic [DW-1:0] tx_returned_data_i = '0;
  logic [4:0]    tx_returned_reg_id_i = '0;
  logic          res_v_o;
  logic [DW-1:0] res_data_o;
  logic [LW-1:0] res_idx_o;
  logic          res_ready_i = 1'b1;

  brg_vvadd_xcel_fetch_ctrl #(
    .data_width_p(DW), .addr_width_p(AW),
    .max_out_credits_p(CR), .len_width_p(LW)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .start_i(start_i),
    .a_addr_i(a_addr_i), .b_addr_i(b_addr_i), .len_i(len_i),
    .signal_addr_i(signal_addr_i), .busy_o(busy_o),
    .done_o(done_o), .tx_v_o(tx_v_o),
    .tx_fetching_o(tx_fetching_o), .tx_addr_o(tx_addr_o),
    .tx_signal_addr_o(tx_signal_addr_o),
    .tx_reg_id_o(tx_reg_id_o), .tx_ready_i(tx_ready_i),
    .tx_credits_i(tx_credits_i),
    .tx_returned_v_i(tx_returned_v_i),
    .tx_returned_data_i(tx_returned_data_i),
    .tx_returned_reg_id_i(tx_returned_reg_id_i),
    .res_v_o(res_v_o), .res_data_o(res_data_o),
    .res_idx_o(res_idx_o), .res_ready_i(res_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct { bit op; int idx; } req_t;

  int n_cmp = 0;
  int n_bad = 0;
  logic [AW-1:0] m_a, m_b, m_sig;
  int m_len;
  logic [DW-1:0] a_mem [32];
  logic [DW-1:0] b_mem [32];
  req_t req_q [$];
  logic [DW-1:0] got_res [$];
  logic [AW-1:0] ld_log [$];
  int ld_cnt, sig_cnt, pop_cnt, done_cnt, sig_pend;
  logic [AW-1:0] last_addr;
  logic [4:0] last_tag;
  bit hold_v = 0;
  bit h_fet;
  logic [4:0] h_tag;
  logic [AW-1:0] h_addr, h_sig;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [63:0] res_at(input int i);
    return (got_res.size() > i) ? 64'(got_res[i]) : 64'hDEAD;
  endfunction

  function automatic logic [63:0] ld_at(input int i);
    return (ld_log.size() > i) ? 64'(ld_log[i]) : 64'hDEAD;
  endfunction

  always @(negedge clk) begin : mon
    bit op;
    int idx;
    if (!reset_n_i) begin
      hold_v = 0;
    end else begin
      if (hold_v) begin
        chk("tx_hold_v", tx_v_o, 1);
        chk("tx_hold_fet", tx_fetching_o, h_fet);
        chk("tx_hold_tag", tx_reg_id_o, h_tag);
        chk("tx_hold_addr", h_fet ? tx_addr_o : tx_signal_addr_o,
            h_fet ? h_addr : h_sig);
      end
      hold_v = tx_v_o && !tx_ready_i;
      h_fet = tx_fetching_o;
      h_tag = tx_reg_id_o;
      h_addr = tx_addr_o;
      h_sig = tx_signal_addr_o;
      if (!tx_v_o) chk("tx_fet_idle", tx_fetching_o, 1);
      if (tx_v_o && tx_ready_i) begin
        if (tx_fetching_o) begin
          op = ld_cnt[0];
          idx = ld_cnt / 2;
          chk("ld_in_range", ld_cnt < 2*m_len, 1);
          chk("ld_addr", tx_addr_o, AW'((op ? m_b : m_a) + idx));
          chk("ld_tag", tx_reg_id_o, {op, 1'b0, 3'(idx)});
          req_q.push_back('{op, idx});
          ld_log.push_back(tx_addr_o);
          last_addr = tx_addr_o;
          last_tag = tx_reg_id_o;
          ld_cnt++;
        end else begin
          chk("sig_addr", tx_signal_addr_o, m_sig);
          chk("sig_tag", tx_reg_id_o, 5'b01111);
          sig_cnt++;
          sig_pend++;
        end
      end
      if (res_v_o && res_ready_i) begin
        chk("res_idx", res_idx_o, pop_cnt);
        if (pop_cnt < 32)
          chk("res_data", res_data_o,
              DW'(a_mem[pop_cnt] + b_mem[pop_cnt]));
        got_res.push_back(res_data_o);
        pop_cnt++;
      end
      if (done_o) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    tx_returned_v_i = 1'b0;
  endtask

  task automatic send(input bit op, input int idx);
    tx_returned_v_i = 1'b1;
    tx_returned_reg_id_i = {op, 1'b0, 3'(idx)};
    tx_returned_data_i = op ? b_mem[idx] : a_mem[idx];
    tick();
  endtask

  task automatic send_sig();
    tx_returned_v_i = 1'b1;
    tx_returned_reg_id_i = 5'b01111;
    tx_returned_data_i = '0;
    tick();
  endtask

  task automatic start_op(input logic [AW-1:0] a, input logic [AW-1:0] b,
                          input logic [AW-1:0] s, input int len);
    m_a = a; m_b = b; m_sig = s; m_len = len;
    ld_cnt = 0; sig_cnt = 0; pop_cnt = 0; sig_pend = 0; done_cnt = 0;
    got_res.delete(); req_q.delete(); ld_log.delete();
    a_addr_i = a; b_addr_i = b; signal_addr_i = s; len_i = LW'(len);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic run_to_done(input int max);
    req_t r;
    int c = 0;
    while (done_cnt < 1 && c < max) begin
      if (req_q.size() > 0) begin
        r = req_q.pop_front();
        send(r.op, r.idx);
      end else if (sig_pend > 0) begin
        sig_pend--;
        send_sig();
      end else begin
        tick();
      end
      c++;
    end
    chk("done_reached", done_cnt, 1);
  endtask

  task automatic wait_ld(input int n, input int max);
    int c = 0;
    while (ld_cnt < n && c < max) begin
      tick();
      c++;
    end
    chk("ld_wait", ld_cnt, n);
  endtask

  task automatic scen1(input string tag);
    for (int i = 0; i < 32; i++) begin
      a_mem[i] = DW'(i);
      b_mem[i] = DW'(10*i);
    end
    start_op(16'h100, 16'h200, 16'h0ABC, 4);
    run_to_done(300);
    repeat (3) tick();
    chk({tag, "_done_once"}, done_cnt, 1);
    chk({tag, "_busy_end"}, busy_o, 0);
    chk({tag, "_loads"}, ld_cnt, 8);
    chk({tag, "_sigs"}, sig_cnt, 1);
    chk({tag, "_ld0"}, ld_at(0), 16'h100);
    chk({tag, "_ld1"}, ld_at(1), 16'h200);
    chk({tag, "_ld2"}, ld_at(2), 16'h101);
    chk({tag, "_ld3"}, ld_at(3), 16'h201);
    chk({tag, "_r0"}, res_at(0), 0);
    chk({tag, "_r1"}, res_at(1), 11);
    chk({tag, "_r2"}, res_at(2), 22);
    chk({tag, "_r3"}, res_at(3), 33);
  endtask

  initial begin : wdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    req_t r;
    int c;
    #1 reset_n_i = 1'b0;
    #4;
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_tx_v", tx_v_o, 0);
    chk("rst_res_v", res_v_o, 0);
    @(posedge clk);
    @(posedge clk);
    #3 reset_n_i = 1'b1;
    tick();

    scen1("s1");

    // B responses first, reverse order, consumer stalled
    for (int i = 0; i < 32; i++) begin
      a_mem[i] = DW'(100 + i);
      b_mem[i] = DW'(7*i + 3);
    end
    res_ready_i = 1'b0;
    start_op(16'h500, 16'h600, 16'h0123, 3);
    wait_ld(6, 100);
    for (int i = 2; i >= 0; i--) send(1'b1, i);
    for (int i = 2; i >= 0; i--) send(1'b0, i);
    req_q.delete();
    repeat (2) tick();
    chk("s2_res_v_held", res_v_o, 1);
    chk("s2_res_idx_held", res_idx_o, 0);
    res_ready_i = 1'b1;
    run_to_done(300);
    chk("s2_r0", res_at(0), 103);
    chk("s2_r1", res_at(1), 111);
    chk("s2_r2", res_at(2), 119);

    // withheld responses: buffer fills at 8 elements
    for (int i = 0; i < 32; i++) begin
      a_mem[i] = DW'(16'hFFF0 + i);
      b_mem[i] = DW'(3*i);
    end
    start_op(16'h300, 16'h400, 16'h0999, 12);
    repeat (80) tick();
    chk("s3_stall_loads", ld_cnt, 16);
    chk("s3_stall_pops", pop_cnt, 0);
    r = req_q.pop_front();
    send(r.op, r.idx);
    r = req_q.pop_front();
    send(r.op, r.idx);
    wait_ld(17, 50);
    chk("s3_pop_one", pop_cnt, 1);
    chk("s3_ld8_addr", last_addr, 16'h0308);
    chk("s3_ld8_tag", last_tag, 5'b00000);
    run_to_done(400);
    chk("s3_pops", pop_cnt, 12);
    chk("s3_r4_wrap", res_at(4), 16'h0000);

    // credit gating and held request under backpressure
    for (int i = 0; i < 32; i++) begin
      a_mem[i] = DW'(i + 5);
      b_mem[i] = DW'(2*i);
    end
    tx_credits_i = '0;
    start_op(16'h010, 16'h020, 16'h0055, 2);
    for (int k = 0; k < 5; k++) begin
      chk("s4_no_credit", tx_v_o, 0);
      tick();
    end
    tx_credits_i = CW'(1);
    tx_ready_i = 1'b0;
    c = 0;
    while (!tx_v_o && c < 10) begin
      tick();
      c++;
    end
    chk("s4_raised", tx_v_o, 1);
    tx_credits_i = '0;
    repeat (3) tick();
    chk("s4_held", tx_v_o, 1);
    chk("s4_held_addr", tx_addr_o, 16'h010);
    tx_ready_i = 1'b1;
    tx_credits_i = CW'(CR);
    run_to_done(300);
    chk("s4_pops", pop_cnt, 2);

    // zero length, then all-ones + 1
    start_op(16'h000, 16'h000, 16'h0777, 0);
    run_to_done(100);
    chk("s5_loads", ld_cnt, 0);
    chk("s5_sigs", sig_cnt, 1);
    a_mem[0] = 16'hFFFF;
    b_mem[0] = 16'h0001;
    start_op(16'h040, 16'h080, 16'h0778, 1);
    run_to_done(100);
    chk("s5_wrap_sum", res_at(0), 0);

    // reset while draining
    for (int i = 0; i < 32; i++) begin
      a_mem[i] = DW'(i);
      b_mem[i] = DW'(10*i);
    end
    res_ready_i = 1'b0;
    start_op(16'h100, 16'h200, 16'h0ABC, 4);
    wait_ld(8, 100);
    while (req_q.size() > 0) begin
      r = req_q.pop_front();
      send(r.op, r.idx);
    end
    repeat (2) tick();
    chk("s6_pre_busy", busy_o, 1);
    chk("s6_pre_res_v", res_v_o, 1);
    #2 reset_n_i = 1'b0;
    #1;
    chk("s6_rst_busy", busy_o, 0);
    chk("s6_rst_res_v", res_v_o, 0);
    chk("s6_rst_tx_v", tx_v_o, 0);
    chk("s6_rst_done", done_o, 0);
    tick();
    #2 reset_n_i = 1'b1;
    req_q.delete();
    sig_pend = 0;
    res_ready_i = 1'b1;
    tick();
    scen1("s6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
